// File: rtl/posit_pkg.sv
// Shared posit helpers for the MAC output path: NaR encoding, posit ReLU and
// FIFO occupancy width.
package posit_pkg;

    localparam int unsigned MAX_W = 32;

    function automatic logic [MAX_W-1:0] posit_nar(input int unsigned w);
        return MAX_W'(1) << (w - 1);
    endfunction

    // NaR keeps its encoding; every other negative posit clamps to zero.
    function automatic logic [MAX_W-1:0] posit_relu(input logic [MAX_W-1:0] p,
                                                   input int unsigned w);
        logic [MAX_W-1:0] r;
        r = p;
        if (p != posit_nar(w) && p[w-1])
            r = '0;
        return r;
    endfunction

    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/posit_out_packer_if.sv
// Output word stream of the posit packer: show-ahead valid/ready handshake.
interface posit_out_packer_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic [WIDTH*LANES-1:0] word_o;
    logic                   vld_o;
    logic                   rdy_i;

    modport master (output word_o, output vld_o, input rdy_i);
    modport slave  (input word_o, input vld_o, output rdy_i);
endinterface

// File: rtl/posit_word_fifo.sv
// Synchronous show-ahead FIFO; the head word is kept in a register so the
// read data and empty flag are register outputs.
module posit_word_fifo
    import posit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int LW    = occ_w(DEPTH),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LW-1:0]     level_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              nempty_q;
    logic              push_ok, pop_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = ~nempty_q;
    assign level_o = count_q;
    assign dout_o  = dout_q;

    always_comb begin
        pop_ok  = pop_i & nempty_q;
        push_ok = push_i & (~full_o | pop_ok);
        rd_d    = pop_ok  ? ptr_inc(rd_q) : rd_q;
        wr_d    = push_ok ? ptr_inc(wr_q) : wr_q;
        count_d = count_q + LW'(push_ok) - LW'(pop_ok);
        // The new head may be the word being written on this very edge.
        dout_d  = '0;
        if (count_d != '0)
            dout_d = (push_ok && wr_q == rd_d) ? din_i : mem_q[rd_d];
    end

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            nempty_q <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            nempty_q <= (count_d != '0);
        end
    end

endmodule

// File: rtl/posit_out_packer.sv
// Packs LANES posit MAC results (optionally ReLU'd) into words and queues them
// for write-back; never stalls the MAC, a full FIFO drops and flags overflow.
module posit_out_packer
    import posit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int DEPTH = 4,
    parameter int RELU  = 1,
    localparam int LW   = occ_w(DEPTH),
    localparam int LCW  = $clog2(LANES)
) (
    input  logic                      clk_i,
    input  logic                      rst,
    input  logic                      vld_i,
    input  logic [WIDTH-1:0]          acc_i,
    input  logic                      flush_i,
    posit_out_packer_if.master        out_if,
    output logic [LW-1:0]             level_o,
    output logic                      ovf_o
);

    logic [WIDTH-1:0]       relu_val;
    logic [WIDTH-1:0]       pack_q [LANES];
    logic [WIDTH-1:0]       lane_d [LANES];
    logic [WIDTH*LANES-1:0] word_d;
    logic [LCW-1:0]         lc_q;
    logic                   ovf_q;
    logic                   last_lane, push, pop, drop;
    logic                   fifo_full, fifo_empty;

    generate
        if (RELU != 0) begin : g_relu
            assign relu_val = WIDTH'(posit_relu(MAX_W'(acc_i), WIDTH));
        end else begin : g_pass
            assign relu_val = acc_i;
        end
    endgenerate

    // Word as it stands after this cycle's write; this is what a push sends.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_d[gi] = (vld_i && lc_q == LCW'(gi)) ? relu_val : pack_q[gi];
            assign word_d[gi*WIDTH +: WIDTH] = lane_d[gi];
        end
    endgenerate

    assign last_lane = (lc_q == LCW'(LANES - 1));
    assign push      = (vld_i & last_lane) | (flush_i & (vld_i | (lc_q != '0)));
    assign pop       = out_if.vld_o & out_if.rdy_i;
    assign drop      = push & fifo_full & ~pop;
    assign ovf_o     = ovf_q;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            lc_q  <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < LANES; i++)
                pack_q[i] <= '0;
        end else begin
            // A dropped word still resets the lane state.
            if (push) begin
                lc_q <= '0;
                for (int i = 0; i < LANES; i++)
                    pack_q[i] <= '0;
            end else if (vld_i) begin
                lc_q <= lc_q + LCW'(1);
                for (int i = 0; i < LANES; i++)
                    pack_q[i] <= lane_d[i];
            end
            if (drop)
                ovf_q <= 1'b1;
        end
    end

    posit_word_fifo #(
        .DATA_W (WIDTH*LANES),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst     (rst),
        .push_i  (push),
        .din_i   (word_d),
        .pop_i   (pop),
        .dout_o  (out_if.word_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign out_if.vld_o = ~fifo_empty;

endmodule

// File: tb/tb_posit_out_packer.sv
// Directed and random stimulus for posit_out_packer with a word scoreboard.
module tb_posit_out_packer;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int WW    = WIDTH * LANES;

    logic             clk_i   = 1'b0;
    logic             rst     = 1'b1;
    logic             vld_i   = 1'b0;
    logic [WIDTH-1:0] acc_i   = '0;
    logic             flush_i = 1'b0;
    logic [2:0]       level_o;
    logic             ovf_o;

    posit_out_packer_if #(.WIDTH(WIDTH), .LANES(LANES)) out_if ();

    posit_out_packer #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .DEPTH (DEPTH),
        .RELU  (1)
    ) dut (
        .clk_i   (clk_i),
        .rst     (rst),
        .vld_i   (vld_i),
        .acc_i   (acc_i),
        .flush_i (flush_i),
        .out_if  (out_if),
        .level_o (level_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    logic [WW-1:0] exp_q[$];
    int            m_lc;
    logic [WW-1:0] m_pack;
    logic          m_ovf;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [WIDTH-1:0] relu_ref(input logic [WIDTH-1:0] a);
        if (a == 8'h80) return a;
        if (a[7])       return 8'h00;
        return a;
    endfunction

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the negedge, advance the model.
    task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic f, input logic r);
        int            pre;
        logic          pop, push;
        logic [WW-1:0] word;
        vld_i = v; acc_i = a; flush_i = f; out_if.rdy_i = r;
        @(negedge clk_i);
        pre = exp_q.size();
        chk("vld_o", WW'(out_if.vld_o), WW'(pre != 0));
        chk("level_o", WW'(level_o), WW'(pre));
        chk("ovf_o", WW'(ovf_o), WW'(m_ovf));
        if (pre != 0)
            chk("word_o", out_if.word_o, exp_q[0]);
        $display("step v=%0d acc=%02h flush=%0d rdy=%0d | vld_o=%0d word_o=%08h level=%0d ovf=%0d",
                 v, a, f, r, out_if.vld_o, out_if.word_o, level_o, ovf_o);
        pop  = (pre != 0) && r;
        push = 1'b0;
        word = '0;
        if (v) begin
            m_pack[m_lc*WIDTH +: WIDTH] = relu_ref(a);
            m_lc++;
        end
        if (m_lc == LANES || (f && m_lc > 0)) begin
            push   = 1'b1;
            word   = m_pack;
            m_pack = '0;
            m_lc   = 0;
        end
        if (pop)
            void'(exp_q.pop_front());
        if (push) begin
            if (pre == DEPTH && !pop) m_ovf = 1'b1;
            else                      exp_q.push_back(word);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; vld_i = 1'b0; flush_i = 1'b0; out_if.rdy_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_lc = 0; m_pack = '0; m_ovf = 1'b0;
        chk("rst_vld_o", WW'(out_if.vld_o), '0);
        chk("rst_word_o", out_if.word_o, '0);
        chk("rst_level_o", WW'(level_o), '0);
        chk("rst_ovf_o", WW'(ovf_o), '0);
        $display("reset: vld_o=%0d word_o=%08h level=%0d ovf=%0d",
                 out_if.vld_o, out_if.word_o, level_o, ovf_o);
    endtask

    initial begin
        out_if.rdy_i = 1'b0;
        reset_dut();

        // ReLU lanes
        step(1, 8'h40, 0, 1); step(1, 8'hC0, 0, 1); step(1, 8'h80, 0, 1); step(1, 8'h01, 0, 1);
        chk("relu_word", out_if.word_o, 32'h0180_0040);
        chk("relu_level", WW'(level_o), 32'd1);
        step(0, 8'h00, 0, 1);
        chk("relu_drained", WW'(level_o), 32'd0);

        // Flush of a partial word, then a flush with nothing pending
        step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(0, 8'h00, 1, 1);
        chk("flush_word", out_if.word_o, 32'h0000_2211);
        step(0, 8'h00, 1, 1);
        chk("flush_empty", WW'(level_o), 32'd0);

        // vld_i and flush_i together on the last lane
        step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1); step(1, 8'h03, 0, 1); step(1, 8'h44, 1, 1);
        chk("same_cycle_word", out_if.word_o, 32'h4403_0201);
        step(0, 8'h00, 1, 1);
        chk("same_cycle_single", WW'(level_o), 32'd0);

        // Overflow under stall: five words into a four-deep FIFO
        for (int i = 0; i < 20; i++) step(1, WIDTH'(i + 1), 0, 0);
        chk("ovf_level", WW'(level_o), 32'd4);
        chk("ovf_set", WW'(ovf_o), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 1);
        chk("ovf_sticky", WW'(ovf_o), 32'd1);

        // Full FIFO: push coincides with pop, ordering across pointer wrap
        reset_dut();
        for (int i = 0; i < 19; i++) step(1, WIDTH'(8'h20 + i), 0, 0);
        step(1, 8'h33, 0, 1);
        chk("full_pop_level", WW'(level_o), 32'd4);
        chk("full_pop_ovf", WW'(ovf_o), 32'd0);
        for (int i = 0; i < 8; i++) step(1, WIDTH'(8'h50 + i), 0, 1);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 1);

        // Reset with a partial word and three queued words
        for (int i = 0; i < 14; i++) step(1, WIDTH'(8'h60 + i), 0, 0);
        reset_dut();
        step(1, 8'h51, 0, 1); step(1, 8'h52, 0, 1); step(1, 8'h53, 0, 1); step(1, 8'h54, 0, 1);
        chk("post_reset_word", out_if.word_o, 32'h5453_5251);

        // Mixed traffic
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) != 0));
        for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
